division_32_bit: RTL and testbench

Sequential 32-bit signed integer divider for the datapath's DIV instruction, the counterpart of the combinational multiplier on the HI/LO path. Accepts a dividend/divisor pair on a start pulse and runs a one-bit-per-cycle non-restoring radix-2 iteration over operand magnitudes. It then sign-corrects the result and presents {remainder, quotient} on a 64-bit output in the same layout the multiplier uses for HI/LO. The control unit holds the DIV instruction until `done`.

---
 rtl/division_32_bit.sv | 129 ++++++++++++
 tb/tb_division_32_bit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/division_32_bit.sv
// Sequential 32-bit signed divider: radix-2 non-restoring iteration on operand
// magnitudes, then sign correction. Result is {remainder, quotient} as {HI, LO}.
module division_32_bit (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [63:0] z
);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    state_t      state, state_next;

    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] b_mag;
    logic [5:0]  count;
    logic        sign_q;
    logic        sign_r;
    logic        dz_pend;

    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic [32:0] rem_shift;
    logic [32:0] rem_step;
    logic [32:0] rem_fix;
    logic [31:0] quo_out;
    logic [31:0] rem_out;

    // Magnitude of 0x8000_0000 wraps back to itself, which is correct read as unsigned.
    assign a_mag_in  = a[31] ? -a : a;
    assign b_mag_in  = b[31] ? -b : b;

    // The sign of R before the shift selects subtract or add-back.
    assign rem_shift = {rem[31:0], quo[31]};
    assign rem_step  = rem[32] ? rem_shift + {1'b0, b_mag} : rem_shift - {1'b0, b_mag};

    assign rem_fix   = rem[32] ? rem + {1'b0, b_mag} : rem;
    assign quo_out   = sign_q ? -quo : quo;
    assign rem_out   = sign_r ? -rem_fix[31:0] : rem_fix[31:0];

    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (b == '0) ? FIX : ITER;
            ITER:    if (count == 6'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!clr) begin
            rem      <= '0;
            quo      <= '0;
            b_mag    <= '0;
            count    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz_pend  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            z        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        if (b == '0) begin
                            // Park the dividend and all-ones quotient until the FIX edge.
                            dz_pend <= 1'b1;
                            rem     <= {1'b0, a};
                            quo     <= '1;
                            sign_q  <= 1'b0;
                            sign_r  <= 1'b0;
                        end else begin
                            dz_pend <= 1'b0;
                            rem     <= '0;
                            quo     <= a_mag_in;
                            b_mag   <= b_mag_in;
                            sign_q  <= a[31] ^ b[31];
                            sign_r  <= a[31];
                            busy    <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    rem   <= rem_step;
                    quo   <= {quo[30:0], ~rem_step[32]};
                    count <= count + 6'd1;
                end
                FIX: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (dz_pend) begin
                        z        <= {rem[31:0], quo};
                        div_zero <= 1'b1;
                    end else begin
                        z        <= {rem_out, quo_out};
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_division_32_bit.sv
// Directed and small-random checks of division_32_bit: results, latency, busy
// window, divide-by-zero, ignored start, back-to-back accept and mid-op reset.
module tb_division_32_bit;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [63:0] z;

    int n_checks = 0;
    int n_fail   = 0;

    division_32_bit dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .z        (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for done (bounded); reports cycles observed and how many had busy high.
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_cnt++;
        end while (!done && cycles < 100);
    endtask

    task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [63:0] exp_z, input logic exp_dz, input int exp_lat);
        int cyc, bcnt;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        wait_done(cyc, bcnt);
        check({tag, "_z"}, z, exp_z);
        check({tag, "_dz"}, {63'd0, div_zero}, {63'd0, exp_dz});
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_busy"}, bcnt, (exp_lat == 1) ? 0 : exp_lat - 1);
    endtask

    initial begin
        int cyc, bcnt, seen;
        logic signed [31:0] sa, sb, eq, er;

        clr   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_z", z, 64'h0);
        check("rst_done", {63'd0, done}, 64'h0);
        check("rst_busy", {63'd0, busy}, 64'h0);
        check("rst_dz", {63'd0, div_zero}, 64'h0);
        clr = 1'b1;
        @(posedge clk);
        #1;

        run_div("p7_p2", 32'd7, 32'd2, {32'h1, 32'h3}, 1'b0, 33);
        run_div("m7_p2", -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 33);
        run_div("p7_m2", 32'd7, -32'sd2, {32'h1, 32'hFFFF_FFFD}, 1'b0, 33);
        run_div("m7_m2", -32'sd7, -32'sd2, {32'hFFFF_FFFF, 32'h3}, 1'b0, 33);
        run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, 33);
        run_div("min_min", 32'h8000_0000, 32'h8000_0000, {32'h0, 32'h1}, 1'b0, 33);
        run_div("one_min", 32'd1, 32'h8000_0000, {32'h1, 32'h0}, 1'b0, 33);
        run_div("max_1", 32'h7FFF_FFFF, 32'd1, {32'h0, 32'h7FFF_FFFF}, 1'b0, 33);
        run_div("zero_5", 32'd0, 32'd5, {32'h0, 32'h0}, 1'b0, 33);
        run_div("small", 32'd5, 32'd7, {32'h5, 32'h0}, 1'b0, 33);
        run_div("dz100", 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 1'b1, 1);
        run_div("dzm1", 32'hFFFF_FFFF, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1'b1, 1);
        run_div("after_dz", 32'd20, 32'd6, {32'h2, 32'h3}, 1'b0, 33);

        // Second start during ITER is ignored; start held into the done cycle is accepted.
        a     = 32'd9;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a     = 32'd50;
        b     = 32'd7;
        start = 1'b1;
        wait_done(cyc, bcnt);
        check("ign_z", z, {32'h0, 32'h3});
        check("ign_lat", cyc, 24);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bcnt);
        check("b2b_z", z, {32'h1, 32'h7});
        check("b2b_lat", cyc, 33);
        check("b2b_busy", bcnt, 32);

        // Reset in the middle of an operation discards it.
        a     = 32'd1000;
        b     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("mid_busy_pre", {63'd0, busy}, 64'h1);
        clr = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        check("mid_z", z, 64'h0);
        check("mid_busy", {63'd0, busy}, 64'h0);
        check("mid_dz", {63'd0, div_zero}, 64'h0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        check("mid_no_done", seen, 0);
        check("mid_z_held", z, 64'h0);
        run_div("post_rst", 32'd20, 32'd6, {32'h2, 32'h3}, 1'b0, 33);

        // Random signed pairs against C-style truncating division.
        for (int i = 0; i < 300; i++) begin
            sa = $urandom;
            sb = (i % 3 == 0) ? $urandom_range(1, 40) : $urandom;
            if (i % 2 == 1) sb = -sb;
            if (i % 5 == 0) sa = sa >>> $urandom_range(0, 28);
            if (sb == 0) sb = 32'sd3;
            if (sa == 32'sh8000_0000 && sb == -32'sd1) sb = 32'sd2;
            eq = sa / sb;
            er = sa % sb;
            run_div("rand", sa, sb, {er, eq}, 1'b0, 33);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
